// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory wait
// freezes, EX-stage forwarding selects and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int LOAD_LATENCY     = 1,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_memRead,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rd,
  input  logic [REG_NUM_BITWIDTH-1:0] if_Rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] if_Rs2,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rs2,
  input  logic                        ex_regWrite,
  input  logic [REG_NUM_BITWIDTH-1:0] ex_Rd,
  input  logic                        mem_regWrite,
  input  logic [REG_NUM_BITWIDTH-1:0] mem_Rd,
  input  logic                        ex_memAccess,
  input  logic                        dmem_ready,
  input  logic                        PCSrc,
  output logic                        pc_hold,
  output logic                        if_hold,
  output logic                        id_hold,
  output logic                        ex_hold,
  output logic                        if_doNOP,
  output logic                        id_doNOP,
  output logic                        ex_doNOP,
  output logic [1:0]                  fwdA,
  output logic [1:0]                  fwdB,
  output logic                        stall_busy,
  output logic [CNT_WIDTH-1:0]        stall_cycles
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LOAD_LATENCY - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       luh, mw;
  logic       freeze, flush, stall;

  assign luh = id_memRead && (id_Rd != '0) && ((id_Rd == if_Rs1) || (id_Rd == if_Rs2));
  assign mw  = ex_memAccess && !dmem_ready;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    freeze    = 1'b0;
    flush     = 1'b0;
    stall     = 1'b0;
    case (state)
      RUN: begin
        if (mw) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (PCSrc) begin
          flush = 1'b1;
        end else if (luh) begin
          stall = 1'b1;
          if (LOAD_LATENCY > 1) begin
            cnt_nxt   = CNT_LOAD;
            state_nxt = LOAD_STALL;
          end
        end
      end
      LOAD_STALL: begin
        if (mw) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (PCSrc) begin
          flush     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else begin
          stall   = 1'b1;
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        // A non-zero cnt marks a load stall that the wait interrupted.
        if (mw) freeze = 1'b1;
        else    state_nxt = (cnt != '0) ? LOAD_STALL : RUN;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
    if (rst) begin
      freeze = 1'b0;
      flush  = 1'b0;
      stall  = 1'b0;
    end
  end

  assign pc_hold  = freeze | stall;
  assign if_hold  = freeze | stall;
  assign id_hold  = freeze;
  assign ex_hold  = freeze;
  assign if_doNOP = flush;
  assign id_doNOP = flush | stall;
  assign ex_doNOP = flush;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= '0;
      stall_busy   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      stall_busy <= (state_nxt != RUN);
      if (pc_hold && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end
  end

  // The EX/MEM result is younger than MEM/WB, so its match wins.
  assign fwdA = (ex_regWrite  && (ex_Rd  != '0) && (ex_Rd  == id_Rs1)) ? 2'b10 :
                (mem_regWrite && (mem_Rd != '0) && (mem_Rd == id_Rs1)) ? 2'b01 : 2'b00;
  assign fwdB = (ex_regWrite  && (ex_Rd  != '0) && (ex_Rd  == id_Rs2)) ? 2'b10 :
                (mem_regWrite && (mem_Rd != '0) && (mem_Rd == id_Rs2)) ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (LOAD_LATENCY 1 and 3,
// 4-bit counter) share stimulus and are compared against a bubble-count model.
module tb_hazard_ctrl;

  localparam logic [6:0] FREEZE = 7'b1111000;
  localparam logic [6:0] FLUSH  = 7'b0000111;
  localparam logic [6:0] STALL  = 7'b1100010;
  localparam int         CMAX   = 15;
  localparam int         LAT [2] = '{1, 3};

  logic       clk = 1'b0;
  logic       rst;
  logic       id_memRead, ex_regWrite, mem_regWrite, ex_memAccess, dmem_ready, PCSrc;
  logic [4:0] id_Rd, if_Rs1, if_Rs2, id_Rs1, id_Rs2, ex_Rd, mem_Rd;

  logic [1:0][6:0] ctl_o;
  logic [1:0][1:0] fa, fb;
  logic [1:0]      busy;
  logic [1:0][3:0] sc;

  int n_vec = 0;
  int n_err = 0;

  // Model state: pending bubbles, waiting on memory, stall count.
  int rem [2], nrem [2], cyc [2], ncyc [2];
  bit wt [2], nwt [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hazard_ctrl #(
      .REG_NUM_BITWIDTH(5),
      .LOAD_LATENCY    (g == 0 ? 1 : 3),
      .CNT_WIDTH       (4)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .id_memRead  (id_memRead),
      .id_Rd       (id_Rd),
      .if_Rs1      (if_Rs1),
      .if_Rs2      (if_Rs2),
      .id_Rs1      (id_Rs1),
      .id_Rs2      (id_Rs2),
      .ex_regWrite (ex_regWrite),
      .ex_Rd       (ex_Rd),
      .mem_regWrite(mem_regWrite),
      .mem_Rd      (mem_Rd),
      .ex_memAccess(ex_memAccess),
      .dmem_ready  (dmem_ready),
      .PCSrc       (PCSrc),
      .pc_hold     (ctl_o[g][6]),
      .if_hold     (ctl_o[g][5]),
      .id_hold     (ctl_o[g][4]),
      .ex_hold     (ctl_o[g][3]),
      .if_doNOP    (ctl_o[g][2]),
      .id_doNOP    (ctl_o[g][1]),
      .ex_doNOP    (ctl_o[g][0]),
      .fwdA        (fa[g]),
      .fwdB        (fb[g]),
      .stall_busy  (busy[g]),
      .stall_cycles(sc[g])
    );
  end

  typedef struct {
    logic       memRead;
    logic [4:0] id_Rd, if_Rs1, if_Rs2, id_Rs1, id_Rs2;
    logic       ex_rw;
    logic [4:0] ex_Rd;
    logic       mem_rw;
    logic [4:0] mem_Rd;
    logic       ex_ma, rdy, pcs;
    logic [6:0] e_ctl;
    logic [1:0] e_a, e_b;
  } vec_t;

  vec_t tab [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; id_memRead = 1'b0; ex_regWrite = 1'b0; mem_regWrite = 1'b0;
    ex_memAccess = 1'b0; dmem_ready = 1'b1; PCSrc = 1'b0;
    id_Rd = '0; if_Rs1 = '0; if_Rs2 = '0; id_Rs1 = '0; id_Rs2 = '0; ex_Rd = '0; mem_Rd = '0;
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (ex_regWrite && ex_Rd != 0 && ex_Rd == rs)    return 2'b10;
    if (mem_regWrite && mem_Rd != 0 && mem_Rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval(input int k, output logic [6:0] ctl);
    int r;
    bit w, mwv, luhv;
    r    = rem[k];
    w    = wt[k];
    ctl  = '0;
    mwv  = ex_memAccess && !dmem_ready;
    luhv = id_memRead && id_Rd != 0 && (id_Rd == if_Rs1 || id_Rd == if_Rs2);
    if (rst) begin
      r = 0; w = 0;
    end else if (w) begin
      if (mwv) ctl = FREEZE;
      else     w = 0;
    end else if (mwv) begin
      ctl = FREEZE; w = 1;
    end else if (PCSrc) begin
      ctl = FLUSH; r = 0;
    end else if (r > 0) begin
      ctl = STALL; r--;
    end else if (luhv) begin
      ctl = STALL; r = LAT[k] - 1;
    end
    nrem[k] = r;
    nwt[k]  = w;
    if (rst)                         ncyc[k] = 0;
    else if (ctl[6] && cyc[k] < CMAX) ncyc[k] = cyc[k] + 1;
    else                             ncyc[k] = cyc[k];
  endtask

  // Inputs are already driven; check combinational outputs, clock, check registered ones.
  task automatic step(input string nm);
    logic [6:0] e;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_eval(k, e);
      check($sformatf("%s L%0d ctl", nm, LAT[k]), 32'(ctl_o[k]), 32'(e));
    end
    check({nm, " fwdA"}, 32'(fa[1]), 32'(fwd_model(id_Rs1)));
    check({nm, " fwdB"}, 32'(fb[1]), 32'(fwd_model(id_Rs2)));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      rem[k] = nrem[k]; wt[k] = nwt[k]; cyc[k] = ncyc[k];
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s L%0d busy", nm, LAT[k]), 32'(busy[k]), 32'(wt[k] || rem[k] > 0));
      check($sformatf("%s L%0d cycles", nm, LAT[k]), 32'(sc[k]), 32'(cyc[k]));
    end
  endtask

  task automatic load_use();
    id_memRead = 1'b1; id_Rd = 5'd5; if_Rs1 = 5'd5; if_Rs2 = 5'd1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; wt[k] = 0; cyc[k] = 0;
    end
    idle();
    rst = 1'b1;
    step("reset");
    step("reset");

    tab[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0, 2'b00, 2'b00};
    tab[1]  = '{1, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, STALL, 2'b00, 2'b00};
    tab[2]  = '{1, 5, 2, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, STALL, 2'b00, 2'b00};
    tab[3]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0, 2'b00, 2'b00};
    tab[4]  = '{1, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, FLUSH, 2'b00, 2'b00};
    tab[5]  = '{1, 5, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, FREEZE, 2'b00, 2'b00};
    tab[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b0, 2'b00, 2'b00};
    tab[7]  = '{0, 0, 0, 0, 7, 0, 1, 7, 1, 7, 0, 1, 0, 7'b0, 2'b10, 2'b00};
    tab[8]  = '{0, 0, 0, 0, 7, 0, 0, 7, 1, 7, 0, 1, 0, 7'b0, 2'b01, 2'b00};
    tab[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 7'b0, 2'b00, 2'b00};
    tab[10] = '{0, 0, 0, 0, 4, 3, 1, 3, 1, 3, 0, 1, 0, 7'b0, 2'b00, 2'b10};
    tab[11] = '{0, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0, 2'b00, 2'b00};

    // Each row is applied from RUN and withdrawn before the next edge.
    for (int i = 0; i < 12; i++) begin
      id_memRead = tab[i].memRead; id_Rd = tab[i].id_Rd;
      if_Rs1 = tab[i].if_Rs1; if_Rs2 = tab[i].if_Rs2;
      id_Rs1 = tab[i].id_Rs1; id_Rs2 = tab[i].id_Rs2;
      ex_regWrite = tab[i].ex_rw; ex_Rd = tab[i].ex_Rd;
      mem_regWrite = tab[i].mem_rw; mem_Rd = tab[i].mem_Rd;
      ex_memAccess = tab[i].ex_ma; dmem_ready = tab[i].rdy; PCSrc = tab[i].pcs;
      #1;
      for (int k = 0; k < 2; k++)
        check($sformatf("tab%0d L%0d ctl", i, LAT[k]), 32'(ctl_o[k]), 32'(tab[i].e_ctl));
      check($sformatf("tab%0d fwdA", i), 32'(fa[1]), 32'(tab[i].e_a));
      check($sformatf("tab%0d fwdB", i), 32'(fb[1]), 32'(tab[i].e_b));
      idle();
      step("tab idle");
    end

    // Load-use pair: one bubble at latency 1, three at latency 3.
    rst = 1'b1; step("seqA rst"); idle();
    load_use(); step("seqA luh");
    idle();
    for (int i = 0; i < 4; i++) step("seqA drain");
    check("seqA L1 total", 32'(sc[0]), 32'd1);
    check("seqA L3 total", 32'(sc[1]), 32'd3);

    // Flush beats a simultaneous load-use.
    rst = 1'b1; step("seqB rst"); idle();
    load_use(); PCSrc = 1'b1; step("seqB flush");
    idle(); step("seqB after");
    check("seqB L3 busy", 32'(busy[1]), 32'd0);

    // Four cycles of memory wait, released the cycle after dmem_ready.
    rst = 1'b1; step("seqC rst"); idle();
    ex_memAccess = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("seqC wait");
    dmem_ready = 1'b1; step("seqC release");
    idle(); step("seqC after");
    check("seqC L1 total", 32'(sc[0]), 32'd4);

    // Reset while LOAD_STALL holds cnt=2.
    rst = 1'b1; step("seqD rst"); idle();
    load_use(); step("seqD luh");
    idle();
    check("seqD L3 in stall", 32'(busy[1]), 32'd1);
    rst = 1'b1; step("seqD mid rst");
    check("seqD L3 busy", 32'(busy[1]), 32'd0);
    check("seqD L3 cycles", 32'(sc[1]), 32'd0);
    idle(); step("seqD after");

    // Memory wait interrupting a load stall resumes the remaining bubbles.
    load_use(); step("seqE luh");
    idle(); step("seqE stall");
    ex_memAccess = 1'b1; dmem_ready = 1'b0;
    step("seqE wait"); step("seqE wait");
    dmem_ready = 1'b1; step("seqE release");
    idle();
    for (int i = 0; i < 3; i++) step("seqE resume");
    check("seqE L3 total", 32'(sc[1]), 32'd5);

    // Saturation of the 4-bit stall counter.
    ex_memAccess = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 20; i++) step("seqF sat");
    check("seqF L3 sat", 32'(sc[1]), 32'd15);
    dmem_ready = 1'b1; step("seqF release");
    idle(); load_use(); step("seqF luh");
    idle(); step("seqF drain");
    check("seqF L1 sat", 32'(sc[0]), 32'd15);

    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      id_memRead   = ($urandom_range(0, 2) == 0);
      id_Rd        = 5'($urandom_range(0, 3));
      if_Rs1       = 5'($urandom_range(0, 3));
      if_Rs2       = 5'($urandom_range(0, 3));
      id_Rs1       = 5'($urandom_range(0, 3));
      id_Rs2       = 5'($urandom_range(0, 3));
      ex_regWrite  = 1'($urandom_range(0, 1));
      ex_Rd        = 5'($urandom_range(0, 3));
      mem_regWrite = 1'($urandom_range(0, 1));
      mem_Rd       = 5'($urandom_range(0, 3));
      ex_memAccess = ($urandom_range(0, 3) == 0);
      dmem_ready   = 1'($urandom_range(0, 1));
      PCSrc        = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
